// File: rtl/demux_stream_sched.sv
// demux_stream_sched: packet-level 1:2 stream scheduler.
// One valid/ready input is steered to one of two lanes, each with a 1-deep
// registered output stage. The lane is chosen in IDLE and held until in_last.
// Optional feature macro: DEMUX_SCHED_RR_EN (mode=1 selects round-robin lane).
module demux_stream_sched #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_dest,
    input  logic          in_last,
    input  logic          mode,
    output logic          out0_valid,
    input  logic          out0_ready,
    output logic [DW-1:0] out0_data,
    output logic          out0_last,
    output logic          out1_valid,
    input  logic          out1_ready,
    output logic [DW-1:0] out1_data,
    output logic          out1_last,
    output logic          busy,
    output logic [7:0]    pkt_cnt0,
    output logic [7:0]    pkt_cnt1
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUTE0 = 2'd1,
        ROUTE1 = 2'd2
    } state_t;

    state_t state;
    logic   target;
    logic   acc0;
    logic   acc1;

`ifdef DEMUX_SCHED_RR_EN
    logic   rr_ptr;

    // Lane choice for the next packet: round-robin pointer or requested dest.
    always_comb begin
        target = mode ? rr_ptr : in_dest;
    end
`else
    // mode has no effect without round-robin support.
    logic   unused_mode;
    assign unused_mode = mode;

    // Lane choice for the next packet is always the requested dest.
    always_comb begin
        target = in_dest;
    end
`endif

    // Accept a beat only while routing, and only when the active stage can take it.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        in_ready = 1'b0;
        case (state)
            ROUTE0:  in_ready = !out0_valid || out0_ready;
            ROUTE1:  in_ready = !out1_valid || out1_ready;
            default: in_ready = 1'b0;
        endcase
        acc0 = in_valid && in_ready && (state == ROUTE0);
        acc1 = in_valid && in_ready && (state == ROUTE1);
        busy = (state != IDLE) || out0_valid || out1_valid;
    end

    // Route FSM, packet counters and both output stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the output data registers are reset too, so a mid-packet reset drops held beats.
            state      <= IDLE;
            out0_valid <= 1'b0;
            out0_data  <= '0;
            out0_last  <= 1'b0;
            out1_valid <= 1'b0;
            out1_data  <= '0;
            out1_last  <= 1'b0;
            pkt_cnt0   <= 8'd0;
            pkt_cnt1   <= 8'd0;
`ifdef DEMUX_SCHED_RR_EN
            rr_ptr     <= 1'b0;
`endif
        end else begin
            // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state <= target ? ROUTE1 : ROUTE0;
                    end
                end
                ROUTE0: begin
                    if (acc0 && in_last) begin
                        state    <= IDLE;
                        pkt_cnt0 <= pkt_cnt0 + 8'd1;
`ifdef DEMUX_SCHED_RR_EN
                        rr_ptr   <= !rr_ptr;
`endif
                    end
                end
                ROUTE1: begin
                    if (acc1 && in_last) begin
                        state    <= IDLE;
                        pkt_cnt1 <= pkt_cnt1 + 8'd1;
`ifdef DEMUX_SCHED_RR_EN
                        rr_ptr   <= !rr_ptr;
`endif
                    end
                end
                default: state <= IDLE;
            endcase

            // Lane 0 stage: load on accept, otherwise drain when the consumer takes it.
            if (acc0) begin
                out0_valid <= 1'b1;
                out0_data  <= in_data;
                out0_last  <= in_last;
            end else if (out0_ready) begin
                out0_valid <= 1'b0;
            end

            // Lane 1 stage: drains independently of which lane is active.
            if (acc1) begin
                out1_valid <= 1'b1;
                out1_data  <= in_data;
                out1_last  <= in_last;
            end else if (out1_ready) begin
                out1_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_demux_stream_sched.sv
// Directed self-checking bench for demux_stream_sched.
// Inputs change 1ns after each rising edge; outputs are sampled there too.
module tb_demux_stream_sched;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_dest;
    logic       in_last;
    logic       mode;
    logic       out0_valid;
    logic       out0_ready;
    logic [7:0] out0_data;
    logic       out0_last;
    logic       out1_valid;
    logic       out1_ready;
    logic [7:0] out1_data;
    logic       out1_last;
    logic       busy;
    logic [7:0] pkt_cnt0;
    logic [7:0] pkt_cnt1;

    int vectors = 0;
    int miscompares = 0;

    demux_stream_sched #(.DW(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_dest    (in_dest),
        .in_last    (in_last),
        .mode       (mode),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out0_last  (out0_last),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out1_last  (out1_last),
        .busy       (busy),
        .pkt_cnt0   (pkt_cnt0),
        .pkt_cnt1   (pkt_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one single-beat packet and check which lane carries it.
    task automatic send_one(input logic dest, input logic [7:0] data, input logic exp_lane);
        in_valid = 1'b1;
        in_dest  = dest;
        in_data  = data;
        in_last  = 1'b1;
        tick();                          // IDLE -> ROUTEx
        tick();                          // beat accepted
        in_valid = 1'b0;
        check("rr_lane0_valid", {31'd0, out0_valid}, {31'd0, !exp_lane});
        check("rr_lane1_valid", {31'd0, out1_valid}, {31'd0, exp_lane});
        check("rr_data", {24'd0, exp_lane ? out1_data : out0_data}, {24'd0, data});
        tick();                          // stage drains, FSM idle
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        in_data    = 8'hA1;
        in_dest    = 1'b1;
        in_last    = 1'b0;
        mode       = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;

        // ---- reset with in_valid high ----
        tick();
        tick();
        check("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
        check("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
        check("rst_out0_data", {24'd0, out0_data}, 32'd0);
        check("rst_out1_last", {31'd0, out1_last}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cnts", {16'd0, pkt_cnt0, pkt_cnt1}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready_low", {31'd0, in_ready}, 32'd0);

        // ---- route by dest: A1,A2,A3 to lane 1 ----
        tick();                          // IDLE -> ROUTE1
        check("route_in_ready_high", {31'd0, in_ready}, 32'd1);
        check("route_busy", {31'd0, busy}, 32'd1);
        check("route_out1_empty", {31'd0, out1_valid}, 32'd0);
        tick();
        check("route_b1", {23'd0, out1_valid, out1_data}, {23'd0, 1'b1, 8'hA1});
        check("route_b1_last", {31'd0, out1_last}, 32'd0);
        check("route_out0_idle1", {31'd0, out0_valid}, 32'd0);
        in_data = 8'hA2;
        tick();
        check("route_b2", {23'd0, out1_valid, out1_data}, {23'd0, 1'b1, 8'hA2});
        check("route_b2_last", {31'd0, out1_last}, 32'd0);
        in_data = 8'hA3;
        in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("route_b3", {23'd0, out1_valid, out1_data}, {23'd0, 1'b1, 8'hA3});
        check("route_b3_last", {31'd0, out1_last}, 32'd1);
        check("route_cnt1", {24'd0, pkt_cnt1}, 32'd1);
        check("route_cnt0", {24'd0, pkt_cnt0}, 32'd0);
        check("route_idle_in_ready", {31'd0, in_ready}, 32'd0);
        check("route_out0_idle2", {31'd0, out0_valid}, 32'd0);
        tick();
        check("route_drained", {31'd0, out1_valid}, 32'd0);
        check("route_not_busy", {31'd0, busy}, 32'd0);

        // ---- round-robin from a fresh reset, all dest=0 ----
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mode  = 1'b1;
`ifdef DEMUX_SCHED_RR_EN
        send_one(1'b0, 8'h10, 1'b0);
        send_one(1'b0, 8'h11, 1'b1);
        send_one(1'b0, 8'h12, 1'b0);
        send_one(1'b0, 8'h13, 1'b1);
        check("rr_cnt0", {24'd0, pkt_cnt0}, 32'd2);
        check("rr_cnt1", {24'd0, pkt_cnt1}, 32'd2);
`else
        send_one(1'b0, 8'h10, 1'b0);
        send_one(1'b0, 8'h11, 1'b0);
        send_one(1'b1, 8'h12, 1'b1);
        send_one(1'b0, 8'h13, 1'b0);
        check("rr_cnt0", {24'd0, pkt_cnt0}, 32'd3);
        check("rr_cnt1", {24'd0, pkt_cnt1}, 32'd1);
`endif
        mode = 1'b0;

        // ---- backpressure on lane 0, 4-beat packet B1..B4 ----
        rst_n = 1'b0;
        tick();
        rst_n      = 1'b1;
        out0_ready = 1'b0;
        in_valid   = 1'b1;
        in_dest    = 1'b0;
        in_data    = 8'hB1;
        in_last    = 1'b0;
        tick();                          // IDLE -> ROUTE0
        check("bp_in_ready_first", {31'd0, in_ready}, 32'd1);
        tick();                          // B1 accepted
        check("bp_b1", {23'd0, out0_valid, out0_data}, {23'd0, 1'b1, 8'hB1});
        check("bp_in_ready_drop", {31'd0, in_ready}, 32'd0);
        in_data = 8'hB2;
        tick();                          // stalled
        check("bp_hold_b1", {23'd0, out0_valid, out0_data}, {23'd0, 1'b1, 8'hB1});
        check("bp_still_stalled", {31'd0, in_ready}, 32'd0);
        out0_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("bp_b2", {23'd0, out0_valid, out0_data}, {23'd0, 1'b1, 8'hB2});
        in_data = 8'hB3;
        tick();
        check("bp_b3", {23'd0, out0_valid, out0_data}, {23'd0, 1'b1, 8'hB3});
        in_data = 8'hB4;
        in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("bp_b4", {22'd0, out0_valid, out0_last, out0_data}, {22'd0, 1'b1, 1'b1, 8'hB4});
        check("bp_cnt0", {24'd0, pkt_cnt0}, 32'd1);
        tick();
        check("bp_drained", {31'd0, out0_valid}, 32'd0);

        // ---- lane switch while lane 0 is stalled ----
        out0_ready = 1'b0;
        in_valid   = 1'b1;
        in_dest    = 1'b0;
        in_data    = 8'hC0;
        in_last    = 1'b1;
        tick();                          // IDLE -> ROUTE0
        tick();                          // C0 accepted, back to IDLE
        check("sw_c0", {23'd0, out0_valid, out0_data}, {23'd0, 1'b1, 8'hC0});
        check("sw_cnt0", {24'd0, pkt_cnt0}, 32'd2);
        in_dest = 1'b1;
        in_data = 8'hD1;
        in_last = 1'b0;
        tick();                          // IDLE -> ROUTE1
        check("sw_in_ready_lane1", {31'd0, in_ready}, 32'd1);
        tick();
        check("sw_d1", {23'd0, out1_valid, out1_data}, {23'd0, 1'b1, 8'hD1});
        check("sw_lane0_held1", {23'd0, out0_valid, out0_data}, {23'd0, 1'b1, 8'hC0});
        in_data = 8'hD2;
        in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("sw_d2", {22'd0, out1_valid, out1_last, out1_data}, {22'd0, 1'b1, 1'b1, 8'hD2});
        check("sw_cnt1", {24'd0, pkt_cnt1}, 32'd1);
        tick();
        check("sw_lane1_drained", {31'd0, out1_valid}, 32'd0);
        check("sw_lane0_held2", {23'd0, out0_valid, out0_data}, {23'd0, 1'b1, 8'hC0});
        check("sw_busy_lane0", {31'd0, busy}, 32'd1);
        out0_ready = 1'b1;
        tick();
        check("sw_lane0_drained", {31'd0, out0_valid}, 32'd0);

        // ---- reset mid-packet after beat 2 of 4 ----
        in_valid = 1'b1;
        in_dest  = 1'b1;
        in_data  = 8'hE0;
        in_last  = 1'b0;
        tick();                          // IDLE -> ROUTE1
        tick();                          // E0
        in_data = 8'hE1;
        tick();                          // E1
        check("mr_before", {23'd0, out1_valid, out1_data}, {23'd0, 1'b1, 8'hE1});
        rst_n = 1'b0;
        #1;
        check("mr_out1_cleared", {23'd0, out1_valid, out1_data}, 32'd0);
        check("mr_in_ready", {31'd0, in_ready}, 32'd0);
        check("mr_busy", {31'd0, busy}, 32'd0);
        check("mr_cnts", {16'd0, pkt_cnt0, pkt_cnt1}, 32'd0);
        in_dest = 1'b0;
        in_data = 8'hF0;
        tick();
        rst_n = 1'b1;
        tick();                          // IDLE -> ROUTE0
        tick();                          // F0
        check("mr_f0", {23'd0, out0_valid, out0_data}, {23'd0, 1'b1, 8'hF0});
        check("mr_out1_empty", {31'd0, out1_valid}, 32'd0);
        check("mr_cnts_mid", {16'd0, pkt_cnt0, pkt_cnt1}, 32'd0);
        in_data = 8'hF1;
        in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("mr_f1", {22'd0, out0_valid, out0_last, out0_data}, {22'd0, 1'b1, 1'b1, 8'hF1});
        check("mr_cnt_done", {16'd0, pkt_cnt0, pkt_cnt1}, {16'd0, 8'd1, 8'd0});
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/demux_stream_sched.md
# demux_stream_sched

Packet-level scheduler that steers one valid/ready input stream onto two output streams, the sequenced, flow-controlled counterpart of the 1:2 demux datapath. A route is chosen at the first beat of each packet and held until the beat carrying `in_last`. Each output has a 1-deep registered stage. Sits between a single producer and two consumer lanes.

## Interface
- `DW`, 8, data width in bits (≥1)
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  input beat accepted when `in_valid && in_ready`
- `in_data`  in  DW  input payload
- `in_dest`  in  1  destination lane (0/1); sampled on the packet's first beat only
- `in_last`  in  1  final beat of packet
- `mode`  in  1  0 = route by `in_dest`, 1 = round-robin (see Configuration)
- `out0_valid` / `out1_valid`  out  1  lane output valid
- `out0_ready` / `out1_ready`  in  1  lane consumer ready
- `out0_data` / `out1_data`  out  DW  lane payload
- `out0_last` / `out1_last`  out  1  lane end-of-packet
- `busy`  out  1  high when state ≠ IDLE or either `outX_valid` is high
- `pkt_cnt0` / `pkt_cnt1`  out  8  completed packets routed per lane, wrap 255→0

## Operation
- Reset (async, `rst_n`=0): state IDLE, `rr_ptr`=0, all `outX_valid`/`outX_data`/`outX_last` = 0, `pkt_cnt0`/`pkt_cnt1` = 0, `in_ready`=0, `busy`=0.
- FSM states: IDLE, ROUTE0, ROUTE1.
- IDLE: `in_ready`=0. On `in_valid`=1, latch target T, then move to ROUTE_T next cycle. T is `in_dest` when `mode`=0, and `rr_ptr` when `mode`=1 (macro defined). No beat is consumed in IDLE.
- ROUTEx: `in_ready = !outx_valid || outx_ready`. An accepted beat loads `outx_data`/`outx_last` and sets `outx_valid`.
- An accepted beat with `in_last`=1 does all of the following: return to IDLE, increment `pkt_cntx`, and toggle `rr_ptr`. `rr_ptr` toggles on every completed packet, regardless of mode.
- Output stage x: `outx_valid` clears on `outx_ready` unless a new beat loads in the same cycle. `outx_data`/`outx_last` are held stable while `outx_valid && !outx_ready`.
- The non-active lane keeps draining its stage independently. A lane switch never waits for the previous lane to empty.
- `in_dest` and `mode` changes mid-packet are ignored. Both are sampled only in IDLE.
- Single-beat packet (`in_last` on the first beat): the full IDLE → ROUTEx → IDLE sequence still applies.

## Timing
- Route decision costs 1 bubble cycle per packet: first beat accepted ≥1 cycle after `in_valid` is seen in IDLE.
- Input-to-output latency: a beat accepted at edge N is visible on `outx_*` after edge N.
- Within a packet, throughput is 1 beat/cycle while `outx_ready`=1 (pass-through when the stage is full and draining).
- Back-to-back packets: ≥1 idle input cycle between the `in_last` beat and the next packet's first accept.
- Reset asserted mid-packet: all state is cleared immediately, and any beats held in the output stages are dropped.

## Configuration
- `DEMUX_SCHED_RR_EN` defined: `mode`=1 selects round-robin targeting from `rr_ptr`.
- Not defined: `mode` is ignored and routing is always by `in_dest`. `rr_ptr` logic may be removed; all other behaviour is identical.

## Test plan
- Reset with `in_valid`=1 → all outputs 0. One cycle after `rst_n` rises, `in_ready` is still 0 (IDLE); it rises on the following cycle.
- Routing by dest: `mode`=0, 3-beat packet 0xA1,0xA2,0xA3 with `in_dest`=1, both readys=1 → identical sequence on `out1`, `out1_last` on 0xA3 only, `out0_valid` never high, `pkt_cnt1`=1.
- Round-robin (macro on): `mode`=1, four 1-beat packets, all with `in_dest`=0 → lanes 0,1,0,1; `pkt_cnt0`=`pkt_cnt1`=2.
- Backpressure: `out0_ready`=0 during a 4-beat packet to lane 0 → `in_ready` drops after the first beat and `out0_data` holds 1st beat. Release `out0_ready` → remaining beats stream at 1/cycle, with none lost or duplicated.
- Lane switch while lane 0 stalled: `out0_ready`=0 holding a beat, then next packet to lane 1 → lane 1 beats delivered and `out0_valid` stays 1 with unchanged data.
- Mid-packet reset after beat 2 of 4 → outputs cleared instantly. A new packet after reset routes correctly with both counters at 0 before completion.
